// File: rtl/count_seq_pkg.sv
// Shared constants for the count sequencer: FSM state encoding, default
// prescaler terminal value and the 4-bit count increment helper.
package count_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned DIV_DEFAULT = 10;
  localparam int unsigned PW_DEFAULT  = 27;

  // Count arithmetic wraps silently at 16.
  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return c + 4'd1;
  endfunction

endpackage

// File: rtl/count_seq_ctrl_tick_gen.sv
// Prescaler for the count sequencer: counts enabled cycles 0..DIV and emits a
// registered one-cycle tick on the cycle after the counter wraps.
module tick_gen #(
  parameter int unsigned DIV = 10,
  parameter int unsigned PW  = 27
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [PW-1:0] TERM = PW'(DIV);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || sync_clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == TERM) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + {{(PW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencer: loads a start value, counts prescaled ticks up to a latched
// terminal value, then reports done. COUNT_SEQ_AUTORELOAD_EN selects auto-reload.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  parameter int unsigned PW  = PW_DEFAULT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] load_val,
  input  logic [3:0] term_val,
  output logic [3:0] Cout,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  // start and stop are single-cycle requests sampled on the rising edge; start
  // is honoured only in IDLE and only when stop is low, stop wins everywhere.
  logic [1:0] state;
  logic [3:0] cout_q;
  logic [3:0] term_q;
  logic [3:0] cout_nxt;
  logic       presc_en;
  logic       presc_clr;

`ifdef COUNT_SEQ_AUTORELOAD_EN
  logic [3:0] load_q;
  logic       at_term_q;
  logic       done_q;
`endif

  // Prescaler also advances on the PAUSE->RUN edge, so a pause costs exactly
  // the number of cycles pause was high.
  assign presc_en  = !pause && !stop && (state == ST_RUN || state == ST_PAUSE);
  assign presc_clr = (state == ST_IDLE) || stop;
  assign cout_nxt  = cnt_inc(cout_q);

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk      (clk),
    .clr      (clr),
    .en       (presc_en),
    .sync_clr (presc_clr),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= ST_IDLE;
      cout_q <= 4'd0;
      term_q <= 4'd0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
      load_q    <= 4'd0;
      at_term_q <= 1'b0;
      done_q    <= 1'b0;
`endif
    end else begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
      done_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            cout_q <= load_val;
            term_q <= term_val;
            state  <= ST_RUN;
`ifdef COUNT_SEQ_AUTORELOAD_EN
            load_q    <= load_val;
            at_term_q <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (tick) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
            // Terminal value is shown for one tick period before reloading.
            if (at_term_q) begin
              cout_q    <= load_q;
              at_term_q <= 1'b0;
            end else begin
              cout_q <= cout_nxt;
              if (cout_nxt == term_q) begin
                at_term_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end
            if (pause) state <= ST_PAUSE;
`else
            cout_q <= cout_nxt;
            if (cout_nxt == term_q) state <= ST_DONE;
            else if (pause)         state <= ST_PAUSE;
`endif
          end else if (pause) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop)        state <= ST_IDLE;
          else if (!pause) state <= ST_RUN;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Cout      = cout_q;
  assign busy      = (state == ST_RUN) || (state == ST_PAUSE);
  assign state_dbg = state;

`ifdef COUNT_SEQ_AUTORELOAD_EN
  assign done = done_q;
`else
  assign done = (state == ST_DONE);
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl (DIV=10, default build): edge-by-edge
// expected count/tick/state for plain, paused, stopped, wrapping and reset runs.
module tb_count_seq_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] load_val;
  logic [3:0] term_val;
  logic [3:0] Cout;
  logic       tick;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int tests_run;
  int tests_failed;

  count_seq_ctrl #(.DIV(10), .PW(27)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .load_val  (load_val),
    .term_val  (term_val),
    .Cout      (Cout),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start at edge 0, then check every edge 1..n_edges. Ticks fall on unpaused
  // edges 11k (k=1..nt), the count moves one edge later, done at 11*nt+1.
  // pause is high for edges p..p+plen-1; stop pulses at edge stop_at (0 = none).
  task automatic run_seq(input logic [3:0] ld, input logic [3:0] tv, input int nt,
                         input int p, input int plen, input int stop_at, input int n_edges);
    int eff, k, st_eff;
    logic [3:0] exp_cout;
    logic [1:0] exp_state;
    logic exp_tick;
    start = 1'b1; load_val = ld; term_val = tv;
    step();
    start = 1'b0; load_val = ~ld; term_val = ~tv;
    check($sformatf("start_state ld%0d", ld), state_dbg, 2'd1);
    check($sformatf("start_cout ld%0d", ld), Cout, ld);
    for (int e = 1; e <= n_edges; e++) begin
      pause = (e >= p) && (e < p + plen);
      stop  = (e == stop_at);
      start = (e == 4);
      if (e == 4) begin load_val = 4'd9; term_val = 4'd9; end
      step();
      pause = 1'b0; stop = 1'b0; start = 1'b0;
      if (e < p)             eff = e;
      else if (e < p + plen) eff = p - 1;
      else                   eff = e - plen;
      exp_tick = 1'b0;
      if (stop_at > 0 && e >= stop_at) begin
        st_eff    = stop_at - 1;
        k         = (st_eff - 1) / 11;
        if (k > nt) k = nt;
        exp_cout  = 4'(ld + k);
        exp_state = 2'd0;
      end else begin
        k = (eff - 1) / 11;
        if (k > nt) k = nt;
        exp_cout = 4'(ld + k);
        if (e >= p && e < p + plen)  exp_state = 2'd2;
        else if (eff <= 11 * nt)     exp_state = 2'd1;
        else if (eff == 11 * nt + 1) exp_state = 2'd3;
        else                         exp_state = 2'd0;
        if (!(e >= p && e < p + plen) && (eff % 11 == 0) && (eff / 11 >= 1) && (eff / 11 <= nt))
          exp_tick = 1'b1;
      end
      check($sformatf("cout ld%0d tv%0d e%0d", ld, tv, e), Cout, exp_cout);
      check($sformatf("state ld%0d tv%0d e%0d", ld, tv, e), state_dbg, exp_state);
      check($sformatf("tick ld%0d tv%0d e%0d", ld, tv, e), tick, exp_tick);
      check($sformatf("done ld%0d tv%0d e%0d", ld, tv, e), done, exp_state == 2'd3);
      check($sformatf("busy ld%0d tv%0d e%0d", ld, tv, e), busy,
            exp_state == 2'd1 || exp_state == 2'd2);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    clr = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    load_val = 4'd0; term_val = 4'd0;
    step(); step();
    check("rst_cout", Cout, 4'd0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    clr = 1'b0;
    step();

    // plain 0->3, paused variant, stop at edge 20, wrap 14->1, full 16-tick wrap
    run_seq(4'd0, 4'd3, 3, 999, 0, 0, 37);
    run_seq(4'd0, 4'd3, 3, 5, 5, 0, 42);
    run_seq(4'd0, 4'd3, 3, 999, 0, 20, 32);
    run_seq(4'd14, 4'd1, 3, 999, 0, 0, 37);
    run_seq(4'd5, 4'd5, 16, 999, 0, 0, 180);

    // clr mid-run with Cout=2; a simultaneous start must be refused
    start = 1'b1; load_val = 4'd0; term_val = 4'd5;
    step();
    start = 1'b0;
    repeat (23) step();
    check("pre_clr_cout", Cout, 4'd2);
    check("pre_clr_busy", busy, 1'b1);
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    check("clr_cout", Cout, 4'd0);
    check("clr_busy", busy, 1'b0);
    check("clr_state", state_dbg, 2'd0);
    check("clr_tick", tick, 1'b0);
    step();
    check("post_clr_state", state_dbg, 2'd0);

    // start with stop in IDLE stays IDLE
    start = 1'b1; stop = 1'b1; load_val = 4'd7; term_val = 4'd9;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_state", state_dbg, 2'd0);
    check("startstop_busy", busy, 1'b0);
    check("startstop_cout", Cout, 4'd0);
    step();
    check("startstop_state2", state_dbg, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
